sap1_datapath: RTL and testbench

//   Execution end of the SAP-1 control interface: consumes the 16-bit control word

---
 rtl/sap1_datapath.sv | 131 +++++++++++++
 tb/tb_sap1_datapath.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: executes the controller's 16-bit control word on a shared
// 8-bit bus. Holds PC, MAR, IR, A, B, ALU, flags, output register and a 16x8 RAM.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ctrl[15:0]        FI JMP CO CI OI BI SUB ALO AI AO II IO RI RO MI HLT (msb..lsb)
//   prog_we/addr/data program-load write port into RAM (works while halted/reset)
//   opcode            IR[7:4], combinational from IR
//   bus, bus_conflict combinational bus value and multi-driver indication
//   out_val/out_valid output register and its one-cycle valid pulse
//   flag_c, flag_z    ALU flags captured on FI
//   halted            sticky halt, cleared only by rst
//   pc                program counter
module sap1_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] bus,
  output logic              bus_conflict,
  output logic [DATA_W-1:0] out_val,
  output logic              out_valid,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DRV_W  = 5;

  localparam int unsigned B_FI  = 15;
  localparam int unsigned B_JMP = 14;
  localparam int unsigned B_CO  = 13;
  localparam int unsigned B_CI  = 12;
  localparam int unsigned B_OI  = 11;
  localparam int unsigned B_BI  = 10;
  localparam int unsigned B_SUB = 9;
  localparam int unsigned B_ALO = 8;
  localparam int unsigned B_AI  = 7;
  localparam int unsigned B_AO  = 6;
  localparam int unsigned B_II  = 5;
  localparam int unsigned B_IO  = 4;
  localparam int unsigned B_RI  = 3;
  localparam int unsigned B_RO  = 2;
  localparam int unsigned B_MI  = 1;
  localparam int unsigned B_HLT = 0;

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DRV_W-1:0]  drv;
  logic              multi_drv;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_r;
  logic              alu_c;

  assign opcode       = ir[DATA_W-1 -: OP_W];
  assign bus_conflict = multi_drv;

  // Bus mux: a single driver passes through, none or several give zero.
  always_comb begin
    drv       = {ctrl[B_CO], ctrl[B_AO], ctrl[B_ALO], ctrl[B_IO], ctrl[B_RO]};
    multi_drv = (drv & (drv - DRV_W'(1))) != '0;
    bus       = '0;
    if (!multi_drv) begin
      bus = ({DATA_W{drv[4]}} & DATA_W'(pc))
          | ({DATA_W{drv[3]}} & a_reg)
          | ({DATA_W{drv[2]}} & alu_r)
          | ({DATA_W{drv[1]}} & DATA_W'(ir[ADDR_W-1:0]))
          | ({DATA_W{drv[0]}} & mem[mar]);
    end
  end

  // ALU: subtract as A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    b_op    = ctrl[B_SUB] ? ~b_reg : b_reg;
    alu_sum = (DATA_W+1)'(a_reg) + (DATA_W+1)'(b_op) + (DATA_W+1)'(ctrl[B_SUB]);
    alu_r   = alu_sum[DATA_W-1:0];
    alu_c   = alu_sum[DATA_W];
  end

  // Register file, PC and halt; all loads sample the pre-edge bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_val   <= '0;
      out_valid <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      halted    <= 1'b0;
    end else if (!halted) begin
      if (ctrl[B_MI]) mar   <= bus[ADDR_W-1:0];
      if (ctrl[B_II]) ir    <= bus;
      if (ctrl[B_AI]) a_reg <= bus;
      if (ctrl[B_BI]) b_reg <= bus;
      if (ctrl[B_OI]) out_val <= bus;
      out_valid <= ctrl[B_OI];
      if (ctrl[B_FI]) begin
        flag_c <= alu_c;
        flag_z <= (alu_r == '0);
      end
      if (ctrl[B_JMP])     pc <= bus[ADDR_W-1:0];
      else if (ctrl[B_CI]) pc <= pc + ADDR_W'(1);
      if (ctrl[B_HLT]) halted <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // RAM: program-load write is issued last so it wins a same-address clash.
  always_ff @(posedge clk) begin
    if (!rst && !halted && ctrl[B_RI]) mem[mar] <= bus;
    if (prog_we) mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_sap1_datapath.sv
// Self-checking bench for sap1_datapath: directed scenarios plus randomized
// control words, compared against an integer-level reference model.
module tb_sap1_datapath;

  localparam logic [15:0] FI  = 16'h8000, JMP = 16'h4000, CO  = 16'h2000, CI = 16'h1000;
  localparam logic [15:0] OI  = 16'h0800, BI  = 16'h0400, SUB = 16'h0200, ALO = 16'h0100;
  localparam logic [15:0] AI  = 16'h0080, AO  = 16'h0040, II  = 16'h0020, IO = 16'h0010;
  localparam logic [15:0] RI  = 16'h0008, RO  = 16'h0004, MI  = 16'h0002, HLT = 16'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  bus;
  logic        bus_conflict;
  logic [7:0]  out_val;
  logic        out_valid;
  logic        flag_c;
  logic        flag_z;
  logic        halted;
  logic [3:0]  pc;

  sap1_datapath dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .bus(bus), .bus_conflict(bus_conflict),
    .out_val(out_val), .out_valid(out_valid),
    .flag_c(flag_c), .flag_z(flag_z), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference machine state as plain integers.
  int m_pc, m_mar, m_ir, m_a, m_b, m_out, m_ov, m_c, m_z, m_h;
  int m_ram [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the combinational bus, advance model, check registers.
  task automatic step(input logic [15:0] c, input bit we = 0, input int wa = 0,
                      input int wd = 0, input bit r = 0);
    int n, src, mb, res, cy, nxt_pc;
    @(negedge clk);
    ctrl = c; prog_we = we; prog_addr = 4'(wa); prog_data = 8'(wd); rst = r;
    #1;
    n = 0; src = 0;
    if ((c & CO)  != 0) begin n++; src = m_pc; end
    if ((c & AO)  != 0) begin n++; src = m_a; end
    if ((c & IO)  != 0) begin n++; src = m_ir % 16; end
    if ((c & RO)  != 0) begin n++; src = m_ram[m_mar]; end
    if ((c & SUB) != 0) begin
      res = (m_a - m_b + 256) % 256;
      cy  = (m_a >= m_b) ? 1 : 0;
    end else begin
      res = (m_a + m_b) % 256;
      cy  = (m_a + m_b > 255) ? 1 : 0;
    end
    if ((c & ALO) != 0) begin n++; src = res; end
    mb = (n == 1) ? src : 0;
    chk("bus", 32'(bus), 32'(mb));
    chk("bus_conflict", 32'(bus_conflict), (n > 1) ? 32'd1 : 32'd0);

    if (r) begin
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
      m_out = 0; m_ov = 0; m_c = 0; m_z = 0; m_h = 0;
    end else if (m_h != 0) begin
      m_ov = 0;
    end else begin
      if ((c & RI) != 0) m_ram[m_mar] = mb;
      if ((c & MI) != 0) m_mar = mb % 16;
      if ((c & II) != 0) m_ir = mb;
      if ((c & AI) != 0) m_a = mb;
      if ((c & BI) != 0) m_b = mb;
      if ((c & OI) != 0) m_out = mb;
      m_ov = ((c & OI) != 0) ? 1 : 0;
      if ((c & FI) != 0) begin m_c = cy; m_z = (res == 0) ? 1 : 0; end
      nxt_pc = m_pc;
      if ((c & JMP) != 0)     nxt_pc = mb % 16;
      else if ((c & CI) != 0) nxt_pc = (m_pc + 1) % 16;
      m_pc = nxt_pc;
      if ((c & HLT) != 0) m_h = 1;
    end
    if (we) m_ram[wa % 16] = wd % 256;

    @(posedge clk);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("opcode", 32'(opcode), 32'(m_ir / 16));
    chk("out_val", 32'(out_val), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("flag_c", 32'(flag_c), 32'(m_c));
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("halted", 32'(halted), 32'(m_h));
  endtask

  // Put a value in ram[0] (MAR held at 0) and move it into a register.
  task automatic load_reg(input logic [15:0] dst, input int val);
    step(16'h0, 1, 0, val);
    step(RO | dst);
  endtask

  initial begin
    logic [15:0] c;
    int sel;
    rst = 1'b1; ctrl = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;

    // Reset while preloading RAM.
    for (int i = 15; i >= 0; i--) step(16'h0, 1, i, (i == 0) ? 32'h1E : 32'(i * 17), 1);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Fetch.
    step(CO | MI);
    step(RO | II | CI);
    chk("fetch_opcode", 32'(opcode), 32'd1);
    chk("fetch_pc", 32'(pc), 32'd1);
    step(RO);  // MAR still 0 -> bus shows 0x1E

    // ADD with carry.
    load_reg(AI, 'hF0);
    load_reg(BI, 'h20);
    step(ALO | AI | FI);
    chk("add_c", 32'(flag_c), 32'd1);
    chk("add_z", 32'(flag_z), 32'd0);
    step(AO);
    chk("add_a", 32'(bus), 32'h10);

    // SUB to zero, then SUB with borrow.
    load_reg(AI, 5);
    load_reg(BI, 5);
    step(SUB | ALO | AI | FI);
    chk("sub_c", 32'(flag_c), 32'd1);
    chk("sub_z", 32'(flag_z), 32'd1);
    load_reg(AI, 3);
    step(SUB | ALO | AI | FI);
    chk("borrow_c", 32'(flag_c), 32'd0);
    step(AO);
    chk("borrow_a", 32'(bus), 32'hFE);

    // PC jump to 15, wrap, then jump via IO (JMP beats CI).
    load_reg(JMP, 'h0F);
    chk("jmp15", 32'(pc), 32'd15);
    step(CI);
    chk("wrap", 32'(pc), 32'd0);
    load_reg(II, 'h17);
    step(IO | JMP | CI);
    chk("jmp_io", 32'(pc), 32'd7);

    // Bus conflict loads zero.
    step(CO | AO | AI);
    step(AO);
    chk("conflict_a", 32'(bus), 32'd0);

    // RI versus prog_we: same address loses, different address both write.
    load_reg(AI, 'h44);
    step(AO | RI, 1, 0, 'h99);
    step(RO);
    chk("we_wins", 32'(bus), 32'h99);
    step(AO | RI, 1, 5, 'h12);
    step(RO);
    chk("ri_other", 32'(bus), 32'h44);

    // Output pulse, halt, writes while halted, reset recovery.
    load_reg(AI, 'h2A);
    step(AO | OI);
    chk("out_val", 32'(out_val), 32'h2A);
    chk("out_pulse", 32'(out_valid), 32'd1);
    step(16'h0);
    chk("out_pulse_end", 32'(out_valid), 32'd0);
    step(HLT);
    step(RO | AI | CI);
    chk("halt_pc", 32'(pc), 32'd7);
    chk("halt_flag", 32'(halted), 32'd1);
    step(AO);
    chk("halt_a", 32'(bus), 32'h2A);
    step(16'h0, 1, 0, 'h5C);
    step(RO);
    chk("halt_prog", 32'(bus), 32'h5C);
    step(16'h0, 0, 0, 0, 1);
    chk("rst_clears_halt", 32'(halted), 32'd0);
    chk("rst_pc2", 32'(pc), 32'd0);

    // Randomized control words, mostly with a single bus driver.
    for (int k = 0; k < 1500; k++) begin
      c = 16'($urandom) & ~(CO | AO | ALO | IO | RO | HLT);
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: c |= CO;
        1: c |= AO;
        2: c |= ALO;
        3: c |= IO;
        4: c |= RO;
        6: c |= 16'($urandom) & (CO | AO | ALO | IO | RO);
        default: ;
      endcase
      if ($urandom_range(0, 99) == 0) c |= HLT;
      step(c, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
